scfetch: RTL

- Instruction-fetch stage directly upstream of the combinational 32x32 instruction ROM (word index = addr[6:2]).
- Holds the PC and drives the ROM address.
- Captures the returned word into a fetch/decode register with a valid/ready handshake toward decode.
- Accepts redirects (branch/jump/jr) from execute and detects the self-jump idle loop ("j to own address") as a halt.

---
 rtl/scfetch_pkg.sv | 20 ++
 rtl/scpc_next.sv | 29 ++
 rtl/scfetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/scfetch_pkg.sv
// Shared definitions for the scfetch instruction-fetch stage.
// Contains the reset PC default, the J opcode, the fetch state encoding and the
// J-type target helper. The fetch and next-PC modules both import this package.
package scfetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [5:0]  OP_J         = 6'b000010;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // J-type target: upper nibble of the delay-slot PC plus the 26-bit word index.
  function automatic logic [31:0] jtarget(input logic [31:0] pc4, input logic [31:0] inst);
    return {pc4[31:28], inst[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/scpc_next.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports: pc_i current PC; redir_valid_i/redir_target_i redirect request; accept_i
//        capture this cycle; halt_hit_i self-jump captured; pc_next_o, pc4_o.
module scpc_next
  import scfetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_target_i,
  input  logic        accept_i,
  input  logic        halt_hit_i,
  output logic [31:0] pc_next_o,
  output logic [31:0] pc4_o
);

  // Wraps modulo 2^32 by construction.
  assign pc4_o = pc_i + 32'd4;

  always_comb begin
    pc_next_o = pc_i;
    if (redir_valid_i) begin
      // Word-align the target so the ROM never sees a misaligned fetch.
      pc_next_o = redir_target_i & ~32'h0000_0003;
    end else if (accept_i && !halt_hit_i) begin
      pc_next_o = pc4_o;
    end
  end

endmodule

// File: rtl/scfetch.sv
// Instruction-fetch stage: holds the PC, addresses the combinational ROM and
// registers the returned word toward decode with a valid/ready handshake.
// Ports: clk, rst (async, active-high); imem_addr/imem_inst ROM interface;
//        redir_valid/redir_target redirect from execute; id_ready/id_valid/
//        id_inst/id_pc/id_pc4 decode interface; halted self-jump indicator;
//        fetch_cnt accepted-instruction counter (only with SCFETCH_PERF_CNT_EN,
//        which also enables the CNT_W parameter).
module scfetch
  import scfetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef SCFETCH_PERF_CNT_EN
  ,parameter int CNT_W = 32
`endif
)(
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_inst,
  input  logic             redir_valid,
  input  logic [31:0]      redir_target,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic             halted
`ifdef SCFETCH_PERF_CNT_EN
  ,output logic [CNT_W-1:0] fetch_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc4;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_pc4_q, id_pc4_d;
  logic         halted_q, halted_d;

  logic redir_go;
  logic accept;
  logic halt_hit;

  // Redirects are dropped during the boot cycle.
  assign redir_go = redir_valid && (state_q != S_BOOT);
  // Only S_RUN captures; the register is free when empty or being drained.
  assign accept   = (state_q == S_RUN) && (!id_valid_q || id_ready);
  // "j to own address" is the program's idle loop.
  assign halt_hit = accept && (imem_inst[31:26] == OP_J) &&
                    (jtarget(pc4, imem_inst) == pc_q);

  scpc_next u_pc_next (
    .pc_i           (pc_q),
    .redir_valid_i  (redir_go),
    .redir_target_i (redir_target),
    .accept_i       (accept),
    .halt_hit_i     (halt_hit),
    .pc_next_o      (pc_d),
    .pc4_o          (pc4)
  );

  always_comb begin
    state_d    = state_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    halted_d   = halted_q;
    if (redir_go) begin
      // Flush: a capture in this cycle (even a halt hit) is discarded.
      id_valid_d = 1'b0;
      halted_d   = 1'b0;
      state_d    = S_RUN;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (accept) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_inst;
            id_pc_d    = pc_q;
            id_pc4_d   = pc4;
            if (halt_hit) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
          end
        end
        S_HALT: begin
          if (id_ready) id_valid_d = 1'b0;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_inst_q  <= 32'h0;
      id_pc_q    <= 32'h0;
      id_pc4_q   <= 32'h0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      halted_q   <= halted_d;
    end
  end

`ifdef SCFETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q;

  // Counts decode handshakes; a redirect does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
    end else if (id_valid_q && id_ready) begin
      fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign halted    = halted_q;

endmodule
